hl_uart_rx: RTL and testbench



---
 rtl/hl_uart_pkg.sv | 13 +
 rtl/hl_sync2.sv | 24 ++
 rtl/hl_uart_rx.sv | 137 +++++++++++++
 tb/tb_hl_uart_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hl_uart_pkg.sv
// Shared UART constants and the receiver state encoding.
package hl_uart_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 667;  // 76.8 MHz / 115200 baud
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;
endpackage

// File: rtl/hl_sync2.sv
// Two-flop synchronizer for an asynchronous level input, with selectable reset value.
module hl_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff1 <= RST_VAL;
            r_ff2 <= RST_VAL;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;
endmodule

// File: rtl/hl_uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer and
// framing-error, break and overrun reporting.
module hl_uart_rx
    import hl_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_uart_rxd,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_rx_ferr,
    output logic       o_rx_break,
    output logic       o_rx_overrun,
    output logic       o_rx_busy
);
    localparam int               HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 w_rxd_s;
    logic                 w_buf_free;
    rx_state_e            r_state, w_state_nx;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
    logic [2:0]           r_bit, w_bit_nx;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_nx;
    logic [DATA_BITS-1:0] r_data, w_data_nx;
    logic                 r_valid, w_valid_nx;
    logic                 r_ferr, w_ferr_nx;
    logic                 r_break, w_break_nx;
    logic                 r_ovr, w_ovr_nx;

    hl_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (i_uart_rxd),
        .o_q  (w_rxd_s)
    );

    // A consumer handshake in the completing cycle frees the slot for the new byte.
    assign w_buf_free = !r_valid || i_rx_ready;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CNT_W'(1);
        w_bit_nx   = r_bit;
        w_shreg_nx = r_shreg;
        w_data_nx  = r_data;
        w_valid_nx = r_valid && !i_rx_ready;
        w_ferr_nx  = r_ferr;
        w_break_nx = 1'b0;
        w_ovr_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (!w_rxd_s) w_state_nx = START;
            end
            START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nx   = '0;
                    w_bit_nx   = '0;
                    w_state_nx = w_rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nx   = '0;
                    w_shreg_nx = {w_rxd_s, r_shreg[DATA_BITS-1:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == LAST_BIT) w_state_nx = STOP;
                end
            end
            STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nx = '0;
                    if (w_buf_free) begin
                        w_data_nx  = r_shreg;
                        w_valid_nx = 1'b1;
                        w_ferr_nx  = !w_rxd_s;
                    end else begin
                        w_ovr_nx = 1'b1;
                    end
                    // Low stop bit: wait for the line to recover before hunting again.
                    if (w_rxd_s) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = WAIT_IDLE;
                        w_break_nx = (r_shreg == '0);
                    end
                end
            end
            WAIT_IDLE: begin
                w_cnt_nx = '0;
                if (w_rxd_s) w_state_nx = IDLE;
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_break <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shreg <= w_shreg_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
            r_break <= w_break_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    assign o_rx_data    = r_data;
    assign o_rx_valid   = r_valid;
    assign o_rx_ferr    = r_ferr;
    assign o_rx_break   = r_break;
    assign o_rx_overrun = r_ovr;
    assign o_rx_busy    = (r_state != IDLE);
endmodule

// File: tb/tb_hl_uart_rx.sv
// Bench for hl_uart_rx: directed scenarios plus randomized frames, checked each
// cycle against a line-history frame decoder and buffer model.
module tb_hl_uart_rx;
    localparam int CPB   = 16;
    localparam int HALF  = CPB / 2;
    localparam int FRAME = HALF + 9 * CPB;   // start-of-frame to mid-stop, in line samples
    localparam int MAXC  = 40000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, rx_break, rx_overrun, rx_busy;

    hl_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_uart_rxd  (uart_rxd),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .i_rx_ready  (rx_ready),
        .o_rx_ferr   (rx_ferr),
        .o_rx_break  (rx_break),
        .o_rx_overrun(rx_overrun),
        .o_rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc++;

    // Line value as seen by the first synchronizer flop at each posedge index.
    bit         lh [MAXC];
    logic       p_rst = 1'b0, p_rdy = 1'b0, p_val = 1'b0;
    int         m_mode = 0;      // 0 hunting, 1 inside a frame, 2 waiting for line high
    int         m_s = 0;         // line index of the start bit's first sample
    logic [7:0] e_data = 8'h00;
    logic       e_valid = 1'b0, e_ferr = 1'b0, e_brk = 1'b0, e_ovr = 1'b0;

    int         n_load = 0, n_ovr = 0, n_brk = 0, n_vcyc = 0, load_cyc = 0;
    logic [8:0] dq [$];

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [8:0] peek(int i);
        return (dq.size() > i) ? dq[i] : 9'h1ff;
    endfunction

    always @(negedge clk) begin : model_cmp
        int         m;
        bit         done, stp, free;
        logic [7:0] b;
        m = cyc;
        done = 0;
        e_brk = 1'b0;
        e_ovr = 1'b0;
        if (!p_rst) begin
            m_mode = 0; e_valid = 1'b0; e_data = 8'h00; e_ferr = 1'b0;
        end else if (m >= 2) begin
            case (m_mode)
                0: if (!lh[m-2]) begin m_mode = 1; m_s = m - 2; end
                1: if (m == m_s + 2 + HALF && lh[m_s+HALF]) m_mode = 0;
                   else if (m == m_s + 2 + FRAME) done = 1;
                default: if (lh[m-2]) m_mode = 0;
            endcase
            free = !e_valid || p_rdy;
            if (e_valid && p_rdy) e_valid = 1'b0;
            if (done) begin
                for (int i = 0; i < 8; i++) b[i] = lh[m_s + HALF + CPB * (i + 1)];
                stp = lh[m_s + FRAME];
                if (free) begin e_data = b; e_valid = 1'b1; e_ferr = !stp; end
                else e_ovr = 1'b1;
                if (stp) m_mode = 0;
                else begin m_mode = 2; e_brk = (b == 8'h00); end
            end
        end
        if (!rst_n) begin
            m_mode = 0; e_valid = 1'b0; e_data = 8'h00; e_ferr = 1'b0;
            e_brk = 1'b0; e_ovr = 1'b0;
            if (m < MAXC) lh[m] = 1'b1;
        end
        checks++;
        if ({rx_valid, rx_data, rx_ferr, rx_break, rx_overrun, rx_busy} !==
            {e_valid, e_data, e_ferr, e_brk, e_ovr, (m_mode != 0)}) begin
            errors++;
            $display("FAIL cycle %0d outputs: got v=%b d=%h ferr=%b brk=%b ovr=%b busy=%b expected v=%b d=%h ferr=%b brk=%b ovr=%b busy=%b",
                     m, rx_valid, rx_data, rx_ferr, rx_break, rx_overrun, rx_busy,
                     e_valid, e_data, e_ferr, e_brk, e_ovr, (m_mode != 0));
        end
        if (rx_valid === 1'b1 && (!p_val || p_rdy)) begin
            n_load++; load_cyc = m; dq.push_back({rx_ferr, rx_data});
        end
        if (rx_overrun === 1'b1) n_ovr++;
        if (rx_break === 1'b1) n_brk++;
        if (rx_valid === 1'b1) n_vcyc++;
        if (m + 1 < MAXC) lh[m+1] = rst_n ? uart_rxd : 1'b1;
        p_rst = rst_n;
        p_rdy = rx_ready;
        p_val = rx_valid;
    end

    task automatic cyc1();
        @(posedge clk);
        #2;
    endtask

    task automatic line(logic v, int n);
        uart_rxd = v;
        repeat (n) cyc1();
    endtask

    task automatic send(logic [7:0] b, logic stp, int stop_len);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(stp, stop_len);
    endtask

    task automatic clr();
        n_load = 0; n_ovr = 0; n_brk = 0; n_vcyc = 0; load_cyc = 0;
        dq.delete();
    endtask

    bit         rnd_done;
    int         s, kind;
    logic [7:0] rb;

    initial begin
        for (int i = 0; i < MAXC; i++) lh[i] = 1'b1;
        #1;
        chk("reset_outputs", {rx_valid, rx_ferr, rx_break, rx_overrun, rx_busy, rx_data}, 0);
        repeat (3) cyc1();
        rst_n = 1'b1;
        line(1'b1, 5);

        // 0xA5 with the consumer always ready
        rx_ready = 1'b1; clr();
        s = cyc + 1;
        send(8'hA5, 1'b1, CPB);
        line(1'b1, 10);
        chk("t1_loads", n_load, 1);
        chk("t1_data", peek(0), {1'b0, 8'hA5});
        chk("t1_latency_in_window", int'((load_cyc - s) >= 153 && (load_cyc - s) <= 156), 1);
        chk("t1_valid_cycles", n_vcyc, 1);

        // buffer full: 0x3C held, 0x81 and 0x55 dropped
        rx_ready = 1'b0; clr();
        send(8'h3C, 1'b1, CPB);
        send(8'h81, 1'b1, CPB);
        line(1'b1, 5);
        send(8'h55, 1'b1, CPB);
        line(1'b1, 10);
        chk("t2_loads", n_load, 1);
        chk("t2_data", rx_data, 8'h3C);
        chk("t2_overruns", n_ovr, 2);
        rx_ready = 1'b1; cyc1(); rx_ready = 1'b0;
        line(1'b1, 3);
        chk("t2_valid_after_consume", rx_valid, 0);

        // short glitch, then a break frame with the line held low
        rx_ready = 1'b1; clr();
        line(1'b0, 6);
        line(1'b1, 8);
        chk("t3_glitch_busy", rx_busy, 0);
        chk("t3_glitch_loads", n_load, 0);
        send(8'h00, 1'b0, 40);
        chk("t3_busy_while_low", rx_busy, 1);
        line(1'b1, 30);
        chk("t3_loads", n_load, 1);
        chk("t3_byte", peek(0), {1'b1, 8'h00});
        chk("t3_breaks", n_brk, 1);
        chk("t3_busy_after_high", rx_busy, 0);

        // framing error followed by a clean frame
        clr();
        send(8'hF0, 1'b0, CPB);
        line(1'b1, 4);
        send(8'h12, 1'b1, CPB);
        line(1'b1, 10);
        chk("t4_loads", n_load, 2);
        chk("t4_first", peek(0), {1'b1, 8'hF0});
        chk("t4_second", peek(1), {1'b0, 8'h12});
        chk("t4_breaks", n_brk, 0);

        // reset in the middle of 0x99 while 0x5A is buffered
        rx_ready = 1'b0;
        send(8'h5A, 1'b1, CPB);
        line(1'b1, 5);
        clr();
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(rb_bit(8'h99, i), CPB);
        line(1'b1, 5);
        chk("t5_pre_reset_valid", rx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", {rx_valid, rx_ferr, rx_break, rx_overrun, rx_busy, rx_data}, 0);
        repeat (3) cyc1();
        chk("t5_reset_held_outputs", {rx_valid, rx_ferr, rx_break, rx_overrun, rx_busy, rx_data}, 0);
        rst_n = 1'b1;
        line(1'b1, 20);
        send(8'h42, 1'b1, CPB);
        line(1'b1, 10);
        chk("t5_loads", n_load, 1);
        chk("t5_data", peek(0), {1'b0, 8'h42});
        rx_ready = 1'b1; cyc1(); rx_ready = 1'b0;

        // consume exactly as the next byte completes
        clr();
        send(8'h11, 1'b1, CPB);
        line(1'b1, 6);
        s = cyc + 1;
        fork
            send(8'h22, 1'b1, CPB);
            begin
                while (cyc < s + 153) cyc1();
                rx_ready = 1'b1;
                cyc1();
                rx_ready = 1'b0;
            end
        join
        line(1'b1, 6);
        chk("t6_loads", n_load, 2);
        chk("t6_first", peek(0), {1'b0, 8'h11});
        chk("t6_data", rx_data, 8'h22);
        chk("t6_valid", rx_valid, 1);
        chk("t6_overruns", n_ovr, 0);

        // randomized frames, glitches, breaks and consumer back-pressure
        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    kind = $urandom_range(0, 7);
                    rb = 8'($urandom);
                    if (kind == 0) line(1'b0, $urandom_range(1, HALF - 1));
                    else if (kind == 1) send(rb, 1'b0, HALF + 1 + $urandom_range(0, 20));
                    else if (kind == 2) send(8'h00, 1'b0, CPB);
                    else send(rb, 1'b1, CPB);
                    line(1'b1, $urandom_range(0, 12));
                end
                line(1'b1, 40);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    rx_ready = ($urandom_range(0, 3) != 0);
                    cyc1();
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic rb_bit(logic [7:0] v, int i);
        return v[i];
    endfunction
endmodule
